// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS hazard/forwarding scoreboard.
// Slot rd fields are stored at a fixed maximum width so one struct serves every REG_ADDR_W.
package mips_pkg;

    localparam int REG_ADDR_W_DEFAULT = 5;
    localparam int RD_MAX_W           = 8;
    localparam int FWD_REGFILE        = 0;

    typedef struct packed {
        logic                valid;
        logic                regw;
        logic [RD_MAX_W-1:0] rd;
        logic                is_load;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '0;

endpackage

// File: rtl/hazard_match.sv
// Youngest-match priority encoder for one source operand over the slot array.
// Slot 1 is the youngest; register 0 never matches.
module hazard_match
    import mips_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 2,
    parameter int SEL_W    = $clog2(DEPTH + 1)
) (
    input  slot_t [DEPTH:1]      slots,
    input  logic [RD_MAX_W-1:0]  src,
    input  logic                 uses,
    output logic [SEL_W-1:0]     sel,
    output logic                 load_hazard
);

    logic found;

    always_comb begin
        sel         = SEL_W'(FWD_REGFILE);
        load_hazard = 1'b0;
        found       = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (!found && uses && (src != '0) && slots[k].valid &&
                slots[k].regw && (slots[k].rd == src)) begin
                found       = 1'b1;
                sel         = SEL_W'(k);
                // Only the youngest producer matters: an older load behind it is irrelevant.
                load_hazard = slots[k].is_load && (k < LOAD_LAT);
            end
        end
    end

endmodule

// File: rtl/mips_hazard_scoreboard.sv
// Hazard and forwarding controller: shift scoreboard of in-flight destinations (slot 1 = E,
// slot DEPTH = W) producing forwarding selects, load-use stall, branch flush and global freeze.
module mips_hazard_scoreboard
    import mips_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT,
    parameter int DEPTH      = 3,
    parameter int LOAD_LAT   = 2,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rs,
    input  logic [REG_ADDR_W-1:0] issue_rt,
    input  logic                  issue_uses_rs,
    input  logic                  issue_uses_rt,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  issue_regw,
    input  logic                  issue_is_load,
    input  logic                  branch_taken,
    input  logic                  ext_stall,
    output logic                  stall,
    output logic                  flush_D,
    output logic                  flush_E,
    output logic [SEL_W-1:0]      fwd_sel_rs,
    output logic [SEL_W-1:0]      fwd_sel_rt,
    output logic [SEL_W-1:0]      inflight_count
);

    if (LOAD_LAT < 1 || LOAD_LAT > DEPTH) begin : g_bad_load_lat
        $error("mips_hazard_scoreboard: LOAD_LAT must lie in 1..DEPTH");
    end
    if (REG_ADDR_W > RD_MAX_W || REG_ADDR_W < 1) begin : g_bad_addr_w
        $error("mips_hazard_scoreboard: REG_ADDR_W exceeds slot rd width");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("mips_hazard_scoreboard: DEPTH must be at least 1");
    end

    slot_t [DEPTH:1] slots;
    slot_t           slot_in;
    logic            lu_rs;
    logic            lu_rt;
    logic            lu;
    logic            bt;

    hazard_match #(
        .DEPTH    (DEPTH),
        .LOAD_LAT (LOAD_LAT),
        .SEL_W    (SEL_W)
    ) u_match_rs (
        .slots       (slots),
        .src         (RD_MAX_W'(issue_rs)),
        .uses        (issue_uses_rs),
        .sel         (fwd_sel_rs),
        .load_hazard (lu_rs)
    );

    hazard_match #(
        .DEPTH    (DEPTH),
        .LOAD_LAT (LOAD_LAT),
        .SEL_W    (SEL_W)
    ) u_match_rt (
        .slots       (slots),
        .src         (RD_MAX_W'(issue_rt)),
        .uses        (issue_uses_rt),
        .sel         (fwd_sel_rt),
        .load_hazard (lu_rt)
    );

    // A freeze holds E, so a taken branch is deferred until ext_stall drops.
    assign bt      = branch_taken && !ext_stall;
    assign lu      = issue_valid && (lu_rs || lu_rt);
    assign stall   = ext_stall || (lu && !bt);
    assign flush_D = bt;
    assign flush_E = bt;

    always_comb begin
        slot_in = SLOT_BUBBLE;
        if (issue_valid && !bt && !lu) begin
            slot_in.valid   = 1'b1;
            slot_in.regw    = issue_regw;
            slot_in.rd      = RD_MAX_W'(issue_rd);
            slot_in.is_load = issue_is_load;
        end
    end

    always_comb begin
        inflight_count = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (slots[k].valid && slots[k].regw) begin
                inflight_count = inflight_count + SEL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slots <= '0;
        end else if (!ext_stall) begin
            for (int k = DEPTH; k >= 2; k--) begin
                slots[k] <= slots[k-1];
            end
            slots[1] <= slot_in;
        end
    end

endmodule

// File: tb/tb_mips_hazard_scoreboard.sv
// Directed bench for mips_hazard_scoreboard: queue-based pipeline model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_mips_hazard_scoreboard;

    localparam int REG_ADDR_W = 5;
    localparam int DEPTH      = 3;
    localparam int LOAD_LAT   = 2;
    localparam int SEL_W      = $clog2(DEPTH + 1);

    logic                  clk;
    logic                  rst;
    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] issue_rs;
    logic [REG_ADDR_W-1:0] issue_rt;
    logic                  issue_uses_rs;
    logic                  issue_uses_rt;
    logic [REG_ADDR_W-1:0] issue_rd;
    logic                  issue_regw;
    logic                  issue_is_load;
    logic                  branch_taken;
    logic                  ext_stall;
    logic                  stall;
    logic                  flush_D;
    logic                  flush_E;
    logic [SEL_W-1:0]      fwd_sel_rs;
    logic [SEL_W-1:0]      fwd_sel_rt;
    logic [SEL_W-1:0]      inflight_count;

    int tests;
    int fails;
    bit chk_en;

    mips_hazard_scoreboard #(
        .REG_ADDR_W (REG_ADDR_W),
        .DEPTH      (DEPTH),
        .LOAD_LAT   (LOAD_LAT),
        .SEL_W      (SEL_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .issue_valid    (issue_valid),
        .issue_rs       (issue_rs),
        .issue_rt       (issue_rt),
        .issue_uses_rs  (issue_uses_rs),
        .issue_uses_rt  (issue_uses_rt),
        .issue_rd       (issue_rd),
        .issue_regw     (issue_regw),
        .issue_is_load  (issue_is_load),
        .branch_taken   (branch_taken),
        .ext_stall      (ext_stall),
        .stall          (stall),
        .flush_D        (flush_D),
        .flush_E        (flush_E),
        .fwd_sel_rs     (fwd_sel_rs),
        .fwd_sel_rt     (fwd_sel_rt),
        .inflight_count (inflight_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model: index 0 is the youngest in-flight instruction (E stage)
    typedef struct {
        bit v;
        bit w;
        int rd;
        bit ld;
    } m_ent_t;

    m_ent_t mq[$];

    function automatic int youngest(int src, bit uses);
        if (!uses || src == 0) return 0;
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].v && mq[i].w && mq[i].rd == src) return i + 1;
        end
        return 0;
    endfunction

    function automatic bit model_lu();
        int ys;
        int yt;
        ys = youngest(int'(issue_rs), issue_uses_rs);
        yt = youngest(int'(issue_rt), issue_uses_rt);
        return issue_valid &&
               ((ys > 0 && mq[ys-1].ld && ys < LOAD_LAT) ||
                (yt > 0 && mq[yt-1].ld && yt < LOAD_LAT));
    endfunction

    function automatic int model_count();
        int c;
        c = 0;
        foreach (mq[i]) if (mq[i].v && mq[i].w) c++;
        return c;
    endfunction

    task automatic model_clear();
        mq.delete();
        for (int i = 0; i < DEPTH; i++) mq.push_back('{0, 0, 0, 0});
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_clear();
        end else if (!ext_stall) begin
            m_ent_t e;
            bit bt;
            bt = branch_taken;
            e = '{0, 0, 0, 0};
            if (issue_valid && !bt && !model_lu())
                e = '{1, issue_regw, int'(issue_rd), issue_is_load};
            mq.push_front(e);
            void'(mq.pop_back());
        end
    end

    // scoreboard check helper
    task automatic chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            bit bt;
            bit lu;
            bt = branch_taken && !ext_stall;
            lu = model_lu();
            chk("m_stall", int'(stall), int'(ext_stall || (lu && !bt)));
            chk("m_flush_D", int'(flush_D), int'(bt));
            chk("m_flush_E", int'(flush_E), int'(bt));
            chk("m_fwd_rs", int'(fwd_sel_rs), youngest(int'(issue_rs), issue_uses_rs));
            chk("m_fwd_rt", int'(fwd_sel_rt), youngest(int'(issue_rt), issue_uses_rt));
            chk("m_count", int'(inflight_count), model_count());
        end
    end

    // driver tasks
    task automatic drive(bit v, int rs, int rt, bit urs, bit urt, int rd, bit w, bit ld,
                         bit bt, bit es);
        issue_valid   = v;
        issue_rs      = REG_ADDR_W'(rs);
        issue_rt      = REG_ADDR_W'(rt);
        issue_uses_rs = urs;
        issue_uses_rt = urt;
        issue_rd      = REG_ADDR_W'(rd);
        issue_regw    = w;
        issue_is_load = ld;
        branch_taken  = bt;
        ext_stall     = es;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (DEPTH) adv();
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        chk_en = 1'b0;
        rst    = 1'b1;
        idle();
        model_clear();
        repeat (2) @(negedge clk);
        chk("rst_stall", int'(stall), 0);
        chk("rst_flush_D", int'(flush_D), 0);
        chk("rst_flush_E", int'(flush_E), 0);
        chk("rst_fwd_rs", int'(fwd_sel_rs), 0);
        chk("rst_count", int'(inflight_count), 0);
        rst = 1'b0;
        adv();
        chk_en = 1'b1;

        // forwarding from E then M
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
        @(negedge clk); chk("fw_cnt0", int'(inflight_count), 0);
        adv();
        drive(1, 3, 0, 1, 0, 4, 1, 0, 0, 0);
        @(negedge clk);
        chk("fw_e_sel", int'(fwd_sel_rs), 1);
        chk("fw_e_stall", int'(stall), 0);
        chk("fw_e_cnt", int'(inflight_count), 1);
        adv();
        drive(1, 3, 3, 1, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("fw_m_rs", int'(fwd_sel_rs), 2);
        chk("fw_m_rt", int'(fwd_sel_rt), 2);
        chk("fw_m_cnt", int'(inflight_count), 2);
        adv();
        drain();

        // load-use: one stall cycle, then forward from slot 2
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
        adv();
        drive(1, 5, 0, 1, 0, 6, 1, 0, 0, 0);
        @(negedge clk);
        chk("lu_stall1", int'(stall), 1);
        chk("lu_cnt1", int'(inflight_count), 1);
        adv();
        @(negedge clk);
        chk("lu_stall2", int'(stall), 0);
        chk("lu_sel2", int'(fwd_sel_rs), 2);
        chk("lu_cnt2", int'(inflight_count), 1);
        adv();
        idle();
        @(negedge clk);
        chk("lu_cnt3", int'(inflight_count), 2);
        adv();
        drain();

        // register zero never forwards
        drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        adv();
        drive(1, 0, 0, 1, 1, 2, 1, 0, 0, 0);
        @(negedge clk);
        chk("z_sel_rs", int'(fwd_sel_rs), 0);
        chk("z_sel_rt", int'(fwd_sel_rt), 0);
        chk("z_stall", int'(stall), 0);
        adv();
        drain();

        // branch beats a pending load-use and squashes the consumer
        drive(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
        adv();
        drive(1, 7, 0, 1, 0, 8, 1, 0, 1, 0);
        @(negedge clk);
        chk("br_flush_D", int'(flush_D), 1);
        chk("br_flush_E", int'(flush_E), 1);
        chk("br_stall", int'(stall), 0);
        adv();
        drive(1, 8, 7, 1, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("br_bubble_rs", int'(fwd_sel_rs), 0);
        chk("br_lw_rt", int'(fwd_sel_rt), 2);
        chk("br_cnt", int'(inflight_count), 1);
        adv();
        drain();

        // freeze holds slots; branch deferred until ext_stall falls
        drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
        adv();
        for (int c = 0; c < 3; c++) begin
            drive(1, 9, 0, 1, 0, 10, 1, 0, (c > 0), 1);
            @(negedge clk);
            chk("fz_stall", int'(stall), 1);
            chk("fz_sel", int'(fwd_sel_rs), 1);
            chk("fz_cnt", int'(inflight_count), 1);
            chk("fz_noflush", int'(flush_D), 0);
            adv();
        end
        drive(1, 9, 0, 1, 0, 10, 1, 0, 1, 0);
        @(negedge clk);
        chk("fz_flush", int'(flush_E), 1);
        chk("fz_unstall", int'(stall), 0);
        adv();
        drive(1, 9, 10, 1, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("fz_after_rs", int'(fwd_sel_rs), 2);
        chk("fz_after_rt", int'(fwd_sel_rt), 0);
        adv();
        drain();

        // asynchronous reset with three writers in flight
        for (int r = 10; r <= 12; r++) begin
            drive(1, 0, 0, 0, 0, r, 1, 0, 0, 0);
            adv();
        end
        drive(1, 10, 12, 1, 1, 0, 0, 0, 0, 0);
        #2;
        chk("ar_pre_cnt", int'(inflight_count), 3);
        chk("ar_pre_rs", int'(fwd_sel_rs), 3);
        chk("ar_pre_rt", int'(fwd_sel_rt), 1);
        rst = 1'b1;
        #1;
        chk("ar_cnt", int'(inflight_count), 0);
        chk("ar_rs", int'(fwd_sel_rs), 0);
        chk("ar_rt", int'(fwd_sel_rt), 0);
        @(negedge clk);
        rst = 1'b0;
        adv();
        idle();
        repeat (2) adv();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mips_hazard_scoreboard.md
Name: mips_hazard_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the in-order MIPS pipeline.
- Tracks every in-flight destination register from Execute through Write-back in a DEPTH-slot shift scoreboard.
- Generates forwarding selects, load-use stalls, branch flushes and a global freeze, so successive pipelines no longer run without hazard protection.
- Sits beside the decode stage. Its outputs drive the IF/ID enable, the ID/EX flush and the ID/EX forwarding-select fields.

Parameters:
- REG_ADDR_W, 5: register address width.
- DEPTH, 3: number of tracked stages after decode (slot 1 = E, slot DEPTH = W).
- LOAD_LAT, 2: first slot index at which load data can be forwarded. A load in a slot below LOAD_LAT forces a stall.
- SEL_W, $clog2(DEPTH+1): width of the forwarding selects and of the in-flight count.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- issue_valid  in  1  decode holds a real instruction
- issue_rs  in  REG_ADDR_W  source A address
- issue_rt  in  REG_ADDR_W  source B address
- issue_uses_rs  in  1  source A is read
- issue_uses_rt  in  1  source B is read
- issue_rd  in  REG_ADDR_W  destination address
- issue_regw  in  1  instruction writes the register file
- issue_is_load  in  1  instruction is a load
- branch_taken  in  1  PC_src of the instruction in E
- ext_stall  in  1  freeze request, e.g. data-memory wait
- stall  out  1  hold PC and IF/ID, insert bubble into ID/EX
- flush_D  out  1  squash IF/ID
- flush_E  out  1  squash ID/EX
- fwd_sel_rs  out  SEL_W  forwarding source for A: 0 = register file, k = slot k
- fwd_sel_rt  out  SEL_W  forwarding source for B, same encoding
- inflight_count  out  SEL_W  number of valid writing slots

Behaviour:
- State:
  - Slots 1..DEPTH, each holding {valid, regw, rd, is_load}.
  - All outputs are combinational from slot state and inputs. There is no extra latency.
- Reset:
  - All slots are cleared asynchronously.
  - With inputs idle this gives stall=0, flush_D=0, flush_E=0, fwd_sel_*=0, inflight_count=0.
  - A reset asserted mid-operation discards all in-flight entries immediately.
- Match rule:
  - Slot k matches source s when valid && regw && rd==s && rd!=0 && the matching uses_* bit is set.
  - fwd_sel for that source is the lowest (youngest) matching k, or 0 if no slot matches.
  - Register 0 never matches.
- Load-use stall:
  - lu = issue_valid && the youngest match for either source is_load with k < LOAD_LAT.
  - Older matches behind a younger non-load match do not cause a stall.
- Output equations, with bt = branch_taken && !ext_stall:
  - stall = ext_stall || (lu && !bt)
  - flush_D = bt
  - flush_E = bt
- Slot update on each rising edge:
  - ext_stall=1: all slots hold. This is a global freeze and overrides everything else.
  - Otherwise slots k+1 <= slot k for k=1..DEPTH-1, and slot DEPTH retires.
  - Slot 1 <= a bubble when bt, lu or !issue_valid. Otherwise slot 1 <= the issued fields.
- Simultaneous events:
  - Branch and load-use together: the flush wins, the stall is suppressed, and the consumer is squashed.
  - Branch and ext_stall together: no flush this cycle. Because E is held, branch_taken is re-presented and the flush occurs on the first cycle ext_stall drops.
- Boundary conditions:
  - DEPTH=1 is legal: only slot 1 exists.
  - LOAD_LAT=1 disables load-use stalls.
  - LOAD_LAT must satisfy 1 <= LOAD_LAT <= DEPTH. Any other value is an elaboration error.
  - inflight_count saturates naturally at DEPTH.

Decomposition:
- Shared package mips_pkg:
  - slot struct type {valid, regw, rd, is_load}
  - REG_ADDR_W default
  - fwd select encoding constant FWD_REGFILE=0
- One natural sub-module: hazard_match.
  - Combinational youngest-match priority encoder over the slot array.
  - Instantiated once per source operand.

Test Plan:
- Forward from E: issue add $3 with rd=3, next cycle issue sub reading rs=3 -> fwd_sel_rs=1, stall=0. One cycle later a third reader of $3 -> fwd_sel=2.
- Load-use: issue lw rd=5, then add rs=5 -> stall=1 for exactly one cycle, then fwd_sel_rs=2. inflight_count goes 1,1,2.
- $zero: writer with rd=0, then reader rs=0 -> fwd_sel_rs=0, stall=0.
- Branch: branch_taken=1 with a load-use pending in decode -> flush_D=1, flush_E=1, stall=0. Slot 1 becomes a bubble next cycle.
- Freeze: ext_stall held 3 cycles with a writer in slot 1 -> slot unchanged, fwd_sel constant, stall=1. Asserting branch_taken during the freeze gives no flush until the cycle ext_stall falls.
- Reset: assert rst asynchronously mid-stream with 3 valid slots -> inflight_count=0 and fwd_sel=0 before the next clk edge.
